s9234_bist_ctrl: RTL
====================

Name: s9234_bist_ctrl

Overview:
Built-in self-test sequencer for the s9234 circuit-under-test (CUT). A 36-bit LFSR generates pseudo-random patterns that drive the CUT's primary inputs. A 39-bit MISR compacts the CUT's primary outputs, and the controller sequences the full run: load, apply N patterns, flush, done. On completion it reports the signature and a pass/fail compare against a golden value, replacing the all-zero, fixed-100-cycle stimulus with a self-checking run.

Parameters:
PI_W, 36, CUT primary-input width (LFSR width); feedback taps 36,25 are fixed.
PO_W, 39, CUT primary-output width (MISR width); feedback taps 39,35 are fixed.
CNT_W, 16, pattern-counter width.

Ports:
CK  in  1  rising-edge clock, shared with the CUT.
RST_N  in  1  asynchronous active-low reset.
start  in  1  begin a run; sampled only in IDLE or DONE.
abort  in  1  synchronous abort; returns the block to IDLE from any state.
pat_count  in  CNT_W  number of patterns to apply; 0 means start is ignored.
seed  in  PI_W  LFSR seed; if 0, 1 is loaded instead.
golden  in  PO_W  expected signature.
cut_po  in  PO_W  CUT primary outputs.
cut_pi  out  PI_W  CUT primary inputs.
busy  out  1  high in LOAD, RUN and FLUSH.
done  out  1  high in DONE.
signature  out  PO_W  MISR contents.
pass  out  1  done && (signature == golden).

Behaviour:
- Reset (async, RST_N=0): state=IDLE, lfsr=0, misr=0, cnt=0, cut_pi=0, busy=0, done=0, pass=0, signature=0.
- LFSR step: lfsr_next = {lfsr[34:0], lfsr[35]^lfsr[24]}.
- MISR step: misr_next = {misr[37:0], misr[38]^misr[34]} ^ cut_po.
- States are IDLE, LOAD, RUN, FLUSH and DONE.
- IDLE: cut_pi=0. If start && pat_count!=0, go to LOAD.
- LOAD (1 cycle): lfsr<=(seed==0 ? 1 : seed), misr<=0, cnt<=0, cut_pi=0. Go to RUN.
- RUN: cut_pi = lfsr (registered value).
  - Each cycle, lfsr steps and cnt increments.
  - The MISR steps only when cnt!=0, so each response is compacted one cycle after its pattern was presented.
  - When cnt==pat_count-1, go to FLUSH.
- FLUSH (1 cycle): cut_pi=0; the MISR steps once. Total compactions = pat_count exactly. Go to DONE.
- DONE: done=1; signature and pass are held. start && pat_count!=0 goes to LOAD (rerun); start with pat_count==0 stays in DONE.
- Latency: with start sampled at edge 0, done rises after edge pat_count+2.
- signature always reflects misr; it is valid only when done=1.
- start while busy is ignored. pat_count and seed are sampled only on the IDLE/DONE→LOAD edge; pat_count is latched internally.
- abort has priority over start and all transitions. Next state is IDLE with cut_pi=0; misr and signature keep their values; done=0.
- Counter cannot wrap: max pat_count = 2^CNT_W−1.

Decomposition:
- Package s9234_bist_pkg holds the PI_W/PO_W constants, tap positions (36/25, 39/35) and the state enum.
- One natural sub-module, bist_misr (parallel-input MISR with enable and clear). The LFSR stays inline.

Test Plan:
- Reset then release; pulse start with pat_count=1, seed=0, cut_po=0 → cut_pi=0x1 for one cycle; done after 3 edges; signature=0; with golden=0, pass=1.
- pat_count=1, cut_po=all-ones → signature=0x7F_FFFF_FFFF. pat_count=2, cut_po=all-ones → signature=0x00_0000_0001.
- seed=1, pat_count=4 → cut_pi sequence 0x1, 0x2, 0x4, 0x8, then 0; busy high for exactly 6 cycles.
- Connect the s9234 CUT and run pat_count=100 with a reference-model golden → pass=1. Flip one golden bit → pass=0.
- Abort in the middle of RUN → IDLE next edge, cut_pi=0, done=0. Assert RST_N low mid-RUN → all outputs 0 immediately, without waiting for a clock edge.
- pat_count=0 with start → stays in IDLE. start pulses during RUN → ignored. start in DONE → new LOAD with fresh latched pat_count/seed.

Source files
------------

// File: rtl/s9234_bist_pkg.sv
// Shared widths, feedback taps, FSM states and step functions
// for the s9234 BIST sequencer.
package s9234_bist_pkg;

    localparam int PI_W  = 36;
    localparam int PO_W  = 39;
    localparam int CNT_W = 16;

    localparam int LFSR_TAP_A = 36;
    localparam int LFSR_TAP_B = 25;
    localparam int MISR_TAP_A = 39;
    localparam int MISR_TAP_B = 35;

    typedef logic [PI_W-1:0]  pi_t;
    typedef logic [PO_W-1:0]  po_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    function automatic pi_t lfsr_step(input pi_t s);
        return {s[PI_W-2:0], s[LFSR_TAP_A-1] ^ s[LFSR_TAP_B-1]};
    endfunction

    function automatic po_t misr_step(input po_t s, input po_t d);
        return {s[PO_W-2:0], s[MISR_TAP_A-1] ^ s[MISR_TAP_B-1]} ^ d;
    endfunction

endpackage

// File: rtl/s9234_bist_ctrl_if.sv
// Control, configuration and CUT-facing signals of the BIST sequencer.
interface s9234_bist_ctrl_if;
    import s9234_bist_pkg::*;

    logic start;
    logic abort;
    cnt_t pat_count;
    pi_t  seed;
    po_t  golden;
    po_t  cut_po;
    pi_t  cut_pi;
    logic busy;
    logic done;
    po_t  signature;
    logic pass;

    modport master (
        output start, abort, pat_count, seed, golden, cut_po,
        input  cut_pi, busy, done, signature, pass
    );

    modport slave (
        input  start, abort, pat_count, seed, golden, cut_po,
        output cut_pi, busy, done, signature, pass
    );

endinterface

// File: rtl/bist_misr.sv
// Parallel-input multiple-input signature register with
// synchronous clear (dominant) and step enable.
module bist_misr
    import s9234_bist_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    input  po_t  data_i,
    output po_t  sig_o
);

    po_t misr_q;
    po_t misr_d;

    always_comb begin
        misr_d = misr_q;
        if (clr_i) begin
            misr_d = '0;
        end else if (en_i) begin
            misr_d = misr_step(misr_q, data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misr_q <= '0;
        end else begin
            misr_q <= misr_d;
        end
    end

    assign sig_o = misr_q;

endmodule

// File: rtl/s9234_bist_ctrl.sv
// BIST sequencer for s9234: LFSR patterns out, MISR compaction in,
// load/run/flush/done control with golden-signature compare.
module s9234_bist_ctrl
    import s9234_bist_pkg::*;
(
    input  logic             CK,
    input  logic             RST_N,
    s9234_bist_ctrl_if.slave bus
);

    state_e state_q;
    pi_t    lfsr_q;
    cnt_t   cnt_q;
    cnt_t   pc_q;
    logic   busy_q;
    logic   done_q;

    logic go;
    logic last;
    logic misr_clr;
    logic misr_en;
    po_t  sig;
    pi_t  seed_fix;

    always_comb begin
        go       = bus.start && (bus.pat_count != '0);
        last     = (cnt_q == pc_q - cnt_t'(1));
        seed_fix = (bus.seed == '0) ? pi_t'(1) : bus.seed;
        misr_clr = !bus.abort && (state_q == ST_LOAD);
        // First RUN cycle has no response yet; FLUSH takes the last one
        misr_en  = !bus.abort &&
                   (((state_q == ST_RUN) && (cnt_q != '0)) ||
                    (state_q == ST_FLUSH));
    end

    bist_misr u_misr (
        .clk_i  (CK),
        .rst_ni (RST_N),
        .clr_i  (misr_clr),
        .en_i   (misr_en),
        .data_i (bus.cut_po),
        .sig_o  (sig)
    );

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state_q <= ST_LOAD;
                        pc_q    <= bus.pat_count;
                        lfsr_q  <= seed_fix;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    cnt_q   <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    cnt_q  <= cnt_q + cnt_t'(1);
                    if (last) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cut_pi    = (state_q == ST_RUN) ? lfsr_q : '0;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = sig;
    assign bus.pass      = done_q && (sig == bus.golden);

endmodule
